// File: rtl/am_demod_pkg.sv
// Shared types and width helpers for the AM envelope demodulator.
package am_demod_pkg;

  // Window FSM: ACC accumulates samples, FULL holds a finished sum that
  // could not be handed to the output register yet.
  typedef enum logic {
    ACC  = 1'b0,
    FULL = 1'b1
  } state_t;

  // Width of the rectified magnitude for a DW-bit signed sample.
  function automatic int mag_w(input int dw);
    return dw - 1;
  endfunction

  // Accumulator / envelope width: magnitude width plus log2 of window length.
  function automatic int acc_w(input int dw, input int log2_dec);
    return dw - 1 + log2_dec;
  endfunction

endpackage

// File: rtl/am_abs_sat.sv
// Saturating full-wave rectifier: |sample|, with the most-negative code
// clamped to the largest positive magnitude so the result fits in DW-1 bits.
module am_abs_sat
  import am_demod_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic signed [DW-1:0]    sample,
  output logic [mag_w(DW)-1:0]    mag
);

  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [DW-1:0] neg;

  // Rectify; -2**(DW-1) has no positive twin, so it saturates to all ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    neg = -sample;
    mag = sample[DW-2:0];
    if (sample == MOST_NEG) begin
      mag = '1;
    end else if (sample[DW-1]) begin
      mag = neg[DW-2:0];
    end
  end

endmodule

// File: rtl/am_demod.sv
// AM envelope demodulator: rectifies each accepted sample, sums N = 2**LOG2_DEC
// magnitudes per window, emits the sum over a valid/ready port and flags
// carrier loss after LOSS_WIN consecutive low-envelope windows.
module am_demod
  import am_demod_pkg::*;
#(
  parameter int DW       = 12,
  parameter int LOG2_DEC = 4,
  parameter int THRESH   = 64,
  parameter int LOSS_WIN = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [DW-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [acc_w(DW, LOG2_DEC)-1:0]  out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            no_carrier
);

  localparam int MW = mag_w(DW);
  localparam int AW = acc_w(DW, LOG2_DEC);
  localparam int LW = $clog2(LOSS_WIN + 1);
  localparam logic [AW:0]   THRESH_V = (AW+1)'(THRESH);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_WIN);

  state_t              state, state_nxt;
  logic [AW-1:0]       acc, acc_nxt, sum, load_val;
  logic [LOG2_DEC-1:0] cnt;
  logic [MW-1:0]       mag;
  logic [LW-1:0]       loss_cnt, loss_nxt;
  logic                accept, last, out_free, load;

  am_abs_sat #(.DW(DW)) u_abs (
    .sample (in_data),
    .mag    (mag)
  );

  assign in_ready = (state == ACC);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (cnt == '1);
  assign out_free = !out_valid || out_ready;
  assign sum      = acc + {{LOG2_DEC{1'b0}}, mag};

  // Next-state, accumulator and output-load decision for the window FSM.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    load      = 1'b0;
    load_val  = sum;
    case (state)
      ACC: begin
        if (accept) begin
          if (last && out_free) begin
            load    = 1'b1;
            acc_nxt = '0;
          end else if (last) begin
            acc_nxt   = sum;
            state_nxt = FULL;
          end else begin
            acc_nxt = sum;
          end
        end
      end
      FULL: begin
        if (out_valid && out_ready) begin
          load      = 1'b1;
          load_val  = acc;
          acc_nxt   = '0;
          state_nxt = ACC;
        end
      end
    endcase
  end

  // Carrier-loss counter value to commit alongside the next output load.
  always_comb begin
    loss_nxt = '0;
    if ({1'b0, load_val} < THRESH_V) begin
      loss_nxt = (loss_cnt == LOSS_MAX) ? loss_cnt : loss_cnt + 1'b1;
    end
  end

  // State registers, output register and carrier-loss flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      loss_cnt   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      no_carrier <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      if (accept) begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        out_data   <= load_val;
        out_valid  <= 1'b1;
        loss_cnt   <= loss_nxt;
        no_carrier <= (loss_nxt == LOSS_MAX);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_am_demod.sv
// Directed bench for am_demod with N=4, THRESH=50, LOSS_WIN=3.
module tb_am_demod;

  localparam int DW = 12;
  localparam int LD = 2;
  localparam int AW = DW - 1 + LD;

  logic                   clk = 1'b0;
  logic                   rst;
  logic signed [DW-1:0]   in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [AW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   no_carrier;

  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;

  am_demod #(.DW(DW), .LOG2_DEC(LD), .THRESH(50), .LOSS_WIN(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .no_carrier (no_carrier)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    if (in_valid && in_ready) accepted++;
    @(posedge clk);
    #1;
  endtask

  // One full window of a constant sample, then idle input.
  task automatic send_window(input logic signed [DW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    repeat (4) tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_no_carrier", 32'(no_carrier), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Four samples of +100: sum 400, valid for exactly one cycle.
    in_valid = 1'b1; in_data = 12'sd100;
    repeat (3) tick();
    check("w100_early_valid", 32'(out_valid), 32'd0);
    tick();
    check("w100_valid", 32'(out_valid), 32'd1);
    check("w100_data", 32'(out_data), 32'd400);
    in_valid = 1'b0;
    tick();
    check("w100_valid_drop", 32'(out_valid), 32'd0);

    // Rectifier saturation and negative samples.
    in_valid = 1'b1;
    in_data = -12'sd2048; tick();
    in_data = -12'sd2048; tick();
    in_data = 12'sd1000;  tick();
    in_data = -12'sd1000; tick();
    in_valid = 1'b0;
    check("sat_valid", 32'(out_valid), 32'd1);
    check("sat_data", 32'(out_data), 32'd6094);
    tick();

    // Backpressure: 12 samples of +10 with the consumer stalled.
    accepted = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 12'sd10;
    repeat (4) tick();
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_data", 32'(out_data), 32'd40);
    check("bp_nc_after1", 32'(no_carrier), 32'd0);
    repeat (4) tick();
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_accepted8", 32'(accepted), 32'd8);
    repeat (4) tick();
    check("bp_stall_accepted", 32'(accepted), 32'd8);
    check("bp_hold_data", 32'(out_data), 32'd40);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_hs1_valid", 32'(out_valid), 32'd1);
    check("bp_hs1_data", 32'(out_data), 32'd40);
    check("bp_hs1_in_ready", 32'(in_ready), 32'd1);
    check("bp_nc_after2", 32'(no_carrier), 32'd0);
    tick();
    check("bp_hs2_drop", 32'(out_valid), 32'd0);
    repeat (3) tick();
    in_valid = 1'b0;
    check("bp_accepted12", 32'(accepted), 32'd12);
    check("bp_third_valid", 32'(out_valid), 32'd1);
    check("bp_third_data", 32'(out_data), 32'd40);
    check("bp_nc_after3", 32'(no_carrier), 32'd1);
    tick();

    // Strong window clears the flag; then carrier loss over three zero windows.
    send_window(12'sd100);
    check("clr_data", 32'(out_data), 32'd400);
    check("clr_nc", 32'(no_carrier), 32'd0);
    send_window(12'sd0);
    check("z1_data", 32'(out_data), 32'd0);
    check("z1_nc", 32'(no_carrier), 32'd0);
    send_window(12'sd0);
    check("z2_nc", 32'(no_carrier), 32'd0);
    send_window(12'sd0);
    check("z3_valid", 32'(out_valid), 32'd1);
    check("z3_nc", 32'(no_carrier), 32'd1);
    send_window(12'sd0);
    check("z4_nc_sat", 32'(no_carrier), 32'd1);
    send_window(12'sd100);
    check("rec_data", 32'(out_data), 32'd400);
    check("rec_nc", 32'(no_carrier), 32'd0);
    tick();

    // Reset mid-window discards the partial sum.
    in_valid = 1'b1; in_data = 12'sd500;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 12'sd7;
    repeat (3) tick();
    check("r7_early_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("r7_valid", 32'(out_valid), 32'd1);
    check("r7_data", 32'(out_data), 32'd28);
    tick();
    check("r7_drop", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/am_demod.md
AM_DEMOD -- requirements
Module: am_demod

Interface
REQ-001 The module SHALL have parameter DW, default 12, meaning signed input sample width in bits (DW >= 4).
REQ-002 The module SHALL have parameter LOG2_DEC, default 4, meaning log2 of the decimation window length N = 2**LOG2_DEC (1..8).
REQ-003 The module SHALL have parameter THRESH, default 64, meaning the envelope level below which a window counts as carrier-absent.
REQ-004 The module SHALL have parameter LOSS_WIN, default 4, meaning the number of consecutive carrier-absent windows that sets no_carrier (>= 1).
REQ-005 The module SHALL use one clock and a synchronous, active-high reset.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; every state change happens on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The module SHALL have port in_data, input, DW bits: signed sampled AM waveform, two's complement.
REQ-009 The module SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 The module SHALL have port in_ready, output, 1 bit: the block accepts a sample; a transfer occurs when in_valid && in_ready.
REQ-011 The module SHALL have port out_data, output, AW = DW-1+LOG2_DEC bits: unsigned envelope, the sum of rectified samples over one window.
REQ-012 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-014 The module SHALL have port no_carrier, output, 1 bit: carrier-loss flag.

Function
REQ-015 The rectifier SHALL compute |in_data| combinationally and saturate the most-negative input -2**(DW-1) to 2**(DW-1)-1, giving a DW-1-bit magnitude.
REQ-016 Each accepted sample's magnitude SHALL be added to an AW-bit accumulator; the accumulator cannot overflow by construction.
REQ-017 A sample counter SHALL count accepted samples 0..N-1 and wrap to 0 on the N-th accepted sample.
REQ-018 The FSM SHALL have two states:
- ACC: accumulating.
- FULL: a window sum is complete but cannot be unloaded.
REQ-019 In ACC, in_ready SHALL be 1; in FULL, in_ready SHALL be 0.
REQ-020 In ACC, on acceptance of the N-th sample, if the output register is empty or is being consumed that same cycle, the complete sum (including this sample) SHALL be loaded into out_data. out_valid SHALL be 1 on the following cycle, and the accumulator SHALL restart from 0 while the FSM stays in ACC.
REQ-021 In ACC, on acceptance of the N-th sample with out_valid=1 and out_ready=0, the complete sum SHALL be held in the accumulator and the FSM SHALL go to FULL.
REQ-022 In FULL, when out_valid && out_ready, the held sum SHALL load into out_data (out_valid stays 1), the accumulator SHALL clear, and the FSM SHALL return to ACC on the next cycle.
REQ-023 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 When out_valid && out_ready with no new load in the same cycle, out_valid SHALL drop the next cycle.
REQ-025 A carrier-loss counter SHALL update whenever a sum is loaded into out_data:
- sum < THRESH: increment, saturating at LOSS_WIN.
- otherwise: clear to 0.
REQ-026 no_carrier SHALL be registered and SHALL equal 1 exactly when the carrier-loss counter equals LOSS_WIN; it updates in the same cycle out_data loads.
REQ-027 Samples presented while in_ready=0 SHALL be neither counted nor accumulated.
REQ-028 Throughput SHALL be one sample per cycle sustained when out_ready=1.

Reset
REQ-029 On reset, the FSM SHALL go to ACC, and the accumulator, sample counter and carrier-loss counter SHALL clear to 0.
REQ-030 On reset, out_data=0, out_valid=0, no_carrier=0, and in_ready=1 on the first cycle after reset.
REQ-031 Reset mid-window or in FULL SHALL discard the partial or held sum, with no output emitted for it.

Structure
REQ-032 Package am_demod_pkg SHALL hold the FSM state enum (ACC, FULL) and the width helper functions for the magnitude width (DW-1) and AW.
REQ-033 The rectifier SHALL be sub-module am_abs_sat: combinational, DW-bit signed in, DW-1-bit unsigned out, with saturation; all other logic stays in am_demod.

Verification (DW=12, LOG2_DEC=2 so N=4, THRESH=50, LOSS_WIN=3)
REQ-034 Four samples of +100 with out_ready=1 SHALL produce out_data=400 with out_valid=1 on the cycle after the 4th sample is accepted, for exactly one cycle.
REQ-035 Samples -2048, -2048, +1000, -1000 SHALL produce out_data=2047+2047+1000+1000=6094.
REQ-036 Backpressure: out_ready=0 and 12 consecutive valid samples of +10 SHALL give out_data=40 held; in_ready SHALL be 0 after the 8th acceptance and samples 9..12 SHALL stall. Raising out_ready SHALL give 40 and then 40 on consecutive handshakes, after which samples 9..12 are accepted.
REQ-037 Three windows of zeros SHALL make no_carrier rise with the 3rd out_data=0 load; a following window of +100 SHALL clear no_carrier with out_data=400.
REQ-038 Two samples of +500 followed by a 1-cycle rst, then four samples of +7, SHALL produce a single out_data=28, with no output for the discarded partial window.
